home_alert_scheduler: RTL and testbench

//  Arbitrates the home-automation request lines (door, fire, window, climate) onto one shared

---
 rtl/home_alert_scheduler.sv | 161 ++++++++++++++++
 tb/tb_home_alert_scheduler.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/home_alert_scheduler.sv
// rtl/home_alert_scheduler.sv - fire-preemptive round-robin grant of home alert requests with climate changeover guard
module home_alert_scheduler #(
    parameter int HOLD_CYCLES  = 8,
    parameter int GUARD_CYCLES = 16,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] req,
    output logic [5:0] grant,
    output logic [2:0] grant_id,
    output logic       busy,
    output logic       grant_change,
    output logic [1:0] climate_lock
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [5:0] FIRE = 6'b000100;

    state_t           state, state_n;
    logic [CNT_W-1:0] hold_cnt, hold_n;
    logic [CNT_W-1:0] guard_cnt, guard_n;
    logic [2:0]       rr_ptr, rr_n;
    logic [1:0]       lock_type, lock_type_n;
    logic [5:0]       grant_n;
    logic             chg_n;
    logic [5:0]       eligible, cand, pick;
    logic             rel;

    // Round-robin positions 0..4 map to request bits FD, RD, W, Heater, Cooler.
    function automatic logic [2:0] pos_bit(input logic [2:0] p);
        case (p)
            3'd0:    pos_bit = 3'd0;
            3'd1:    pos_bit = 3'd1;
            3'd2:    pos_bit = 3'd3;
            3'd3:    pos_bit = 3'd4;
            default: pos_bit = 3'd5;
        endcase
    endfunction

    function automatic logic [2:0] bit_pos(input logic [5:0] g);
        case (g)
            6'b000001: bit_pos = 3'd0;
            6'b000010: bit_pos = 3'd1;
            6'b001000: bit_pos = 3'd2;
            6'b010000: bit_pos = 3'd3;
            default:   bit_pos = 3'd4;
        endcase
    endfunction

    function automatic logic [5:0] rr_pick(input logic [5:0] m, input logic [2:0] ptr);
        logic [5:0] r;
        logic [2:0] p;
        logic [2:0] b;
        r = '0;
        p = ptr;
        for (int k = 0; k < 5; k++) begin
            p = (p == 3'd4) ? 3'd0 : p + 3'd1;
            b = pos_bit(p);
            if (r == '0 && m[b]) r[b] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [2:0] onehot_id(input logic [5:0] g);
        logic [2:0] id;
        id = '0;
        for (int i = 0; i < 6; i++) begin
            if (g[i]) id = 3'(i + 1);
        end
        return id;
    endfunction

    assign climate_lock = lock_type & {2{guard_cnt != '0}};

    always_comb begin
        eligible    = req & ~{climate_lock[1], climate_lock[0], 4'b0};
        // While one climate type holds, the other is never a direct successor.
        cand        = eligible & ~grant & ~{grant[4], grant[5], 4'b0};
        pick        = rr_pick((state == IDLE) ? eligible : cand, rr_ptr);
        state_n     = state;
        grant_n     = grant;
        hold_n      = (hold_cnt != '0) ? hold_cnt - CNT_W'(1) : '0;
        rr_n        = rr_ptr;
        chg_n       = 1'b0;
        rel         = 1'b0;
        case (state)
            IDLE: begin
                if (eligible[2]) begin
                    grant_n = FIRE;
                    state_n = GRANT;
                    hold_n  = CNT_W'(HOLD_CYCLES - 1);
                    chg_n   = 1'b1;
                end else if (pick != '0) begin
                    grant_n = pick;
                    rr_n    = bit_pos(pick);
                    state_n = GRANT;
                    hold_n  = CNT_W'(HOLD_CYCLES - 1);
                    chg_n   = 1'b1;
                end
            end
            GRANT: begin
                if (!grant[2] && eligible[2]) begin
                    grant_n = FIRE;
                    hold_n  = CNT_W'(HOLD_CYCLES - 1);
                    chg_n   = 1'b1;
                end else if (hold_cnt == '0) begin
                    rel = grant[2] ? !req[2] : (((req & grant) == '0) || (cand != '0));
                    if (rel) begin
                        if (pick != '0) begin
                            grant_n = pick;
                            rr_n    = bit_pos(pick);
                            hold_n  = CNT_W'(HOLD_CYCLES - 1);
                            chg_n   = 1'b1;
                        end else begin
                            grant_n = '0;
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        lock_type_n = lock_type;
        guard_n     = (guard_cnt != '0) ? guard_cnt - CNT_W'(1) : '0;
        if (grant[4] && !grant_n[4]) begin
            guard_n     = CNT_W'(GUARD_CYCLES);
            lock_type_n = 2'b10;
        end else if (grant[5] && !grant_n[5]) begin
            guard_n     = CNT_W'(GUARD_CYCLES);
            lock_type_n = 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            guard_cnt    <= '0;
            lock_type    <= '0;
            rr_ptr       <= 3'd4;
            grant        <= '0;
            grant_id     <= '0;
            busy         <= 1'b0;
            grant_change <= 1'b0;
        end else begin
            state        <= state_n;
            hold_cnt     <= hold_n;
            guard_cnt    <= guard_n;
            lock_type    <= lock_type_n;
            rr_ptr       <= rr_n;
            grant        <= grant_n;
            grant_id     <= onehot_id(grant_n);
            busy         <= |grant_n;
            grant_change <= chg_n;
        end
    end

endmodule

// File: tb/tb_home_alert_scheduler.sv
// tb/tb_home_alert_scheduler.sv - directed table and sequence checks for home_alert_scheduler
module tb_home_alert_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] req = '0;
    logic [5:0] grant;
    logic [2:0] grant_id;
    logic       busy;
    logic       grant_change;
    logic [1:0] climate_lock;

    int checks = 0;
    int errors = 0;

    home_alert_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .grant        (grant),
        .grant_id     (grant_id),
        .busy         (busy),
        .grant_change (grant_change),
        .climate_lock (climate_lock)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_first;
        logic [5:0] req;
        logic [5:0] grant;
        logic [2:0] id;
        logic       chg;
        logic [1:0] lock;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [5:0] q, input logic [5:0] g,
                                input logic [2:0] id, input logic c, input logic [1:0] l);
        vec_t v;
        v.rst_first = r; v.req = q; v.grant = g; v.id = id; v.chg = c; v.lock = l;
        vecs.push_back(v);
    endfunction

    function automatic logic [12:0] outs();
        return {grant, grant_id, busy, grant_change, climate_lock};
    endfunction

    function automatic logic [12:0] exp_of(input logic [5:0] g, input logic [2:0] id,
                                           input logic c, input logic [1:0] l);
        return {g, id, (g != 6'h00), c, l};
    endfunction

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got grant=%b id=%0d busy=%b chg=%b lock=%b, expected grant=%b id=%0d busy=%b chg=%b lock=%b",
                     name, got[12:7], got[6:4], got[3], got[2], got[1:0],
                     exp[12:7], exp[6:4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // single door request, held for the minimum on-time then idle
        add(1, 6'h01, 6'h01, 3'd1, 1, 2'b00);
        add(0, 6'h01, 6'h01, 3'd1, 0, 2'b00);
        for (int i = 0; i < 6; i++) add(0, 6'h00, 6'h01, 3'd1, 0, 2'b00);
        add(0, 6'h00, 6'h00, 3'd0, 0, 2'b00);
        add(0, 6'h00, 6'h00, 3'd0, 0, 2'b00);
        // FD/RD/W rotation with constant requests
        add(1, 6'h0B, 6'h01, 3'd1, 1, 2'b00);
        for (int i = 0; i < 7; i++) add(0, 6'h0B, 6'h01, 3'd1, 0, 2'b00);
        add(0, 6'h0B, 6'h02, 3'd2, 1, 2'b00);
        for (int i = 0; i < 7; i++) add(0, 6'h0B, 6'h02, 3'd2, 0, 2'b00);
        add(0, 6'h0B, 6'h08, 3'd4, 1, 2'b00);
        for (int i = 0; i < 7; i++) add(0, 6'h0B, 6'h08, 3'd4, 0, 2'b00);
        add(0, 6'h0B, 6'h01, 3'd1, 1, 2'b00);
        // heater -> guard -> cooler, with a door grant inside the guard window
        add(1, 6'h30, 6'h10, 3'd5, 1, 2'b00);
        for (int i = 0; i < 9; i++) add(0, 6'h30, 6'h10, 3'd5, 0, 2'b00);
        for (int i = 0; i < 4; i++) add(0, 6'h20, 6'h00, 3'd0, 0, 2'b10);
        add(0, 6'h21, 6'h01, 3'd1, 1, 2'b10);
        for (int i = 0; i < 7; i++) add(0, 6'h20, 6'h01, 3'd1, 0, 2'b10);
        for (int i = 0; i < 4; i++) add(0, 6'h20, 6'h00, 3'd0, 0, 2'b10);
        add(0, 6'h20, 6'h00, 3'd0, 0, 2'b00);
        add(0, 6'h20, 6'h20, 3'd6, 1, 2'b00);
        add(0, 6'h20, 6'h20, 3'd6, 0, 2'b00);

        step(2);
        check("reset_state", outs(), exp_of(6'h00, 3'd0, 0, 2'b00));
        rst = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].rst_first) do_reset();
            req = vecs[i].req;
            step(1);
            check($sformatf("vec%0d", i), outs(),
                  exp_of(vecs[i].grant, vecs[i].id, vecs[i].chg, vecs[i].lock));
        end

        // fire preempts a held door grant, door resumes after fire
        do_reset();
        req = 6'h01;
        step(1);
        check("fire_seq_c1", outs(), exp_of(6'h01, 3'd1, 1, 2'b00));
        step(2);
        req = 6'h05;
        step(1);
        check("fire_preempt_c4", outs(), exp_of(6'h04, 3'd3, 1, 2'b00));
        step(2);
        req = 6'h01;
        step(5);
        check("fire_hold_c11", outs(), exp_of(6'h04, 3'd3, 0, 2'b00));
        step(1);
        check("fire_resume_c12", outs(), exp_of(6'h01, 3'd1, 1, 2'b00));

        // all requests from reset: fire first, then rotation FD, RD
        do_reset();
        req = 6'h3F;
        step(1);
        check("all_fire_c1", outs(), exp_of(6'h04, 3'd3, 1, 2'b00));
        req = 6'h3B;
        step(7);
        check("all_fire_c8", outs(), exp_of(6'h04, 3'd3, 0, 2'b00));
        step(1);
        check("all_fd_c9", outs(), exp_of(6'h01, 3'd1, 1, 2'b00));
        step(8);
        check("all_rd_c17", outs(), exp_of(6'h02, 3'd2, 1, 2'b00));

        // async reset between edges while granted and locked
        do_reset();
        req = 6'h10;
        step(1);
        check("ar_heater_c1", outs(), exp_of(6'h10, 3'd5, 1, 2'b00));
        req = 6'h00;
        step(8);
        check("ar_idle_lock_c9", outs(), exp_of(6'h00, 3'd0, 0, 2'b10));
        req = 6'h01;
        step(1);
        check("ar_fd_c10", outs(), exp_of(6'h01, 3'd1, 1, 2'b10));
        #2 rst = 1'b1;
        #1 check("ar_async_clear", outs(), exp_of(6'h00, 3'd0, 0, 2'b00));
        #1 rst = 1'b0;
        step(1);
        check("ar_regrant", outs(), exp_of(6'h01, 3'd1, 1, 2'b00));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
